janelamento: RTL and testbench
==============================

# janelamento

Hamming-window stage placed directly downstream of `overlap`. It consumes the overlapped PCM sample stream one sample per handshake and multiplies each sample by the Hamming coefficient for its position in the frame. It emits windowed samples with an end-of-frame tag to the spectral stage. The block is a stall-all, two-stage pipeline with a frame-position counter and a symmetric coefficient ROM.

## Interface
Parameters:
- `DATA_W`, 16: signed PCM sample width.
- `COEF_W`, 16: unsigned coefficient width, Q1.15.
- `N`, 256: frame length in samples. Even, at least 4.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-low reset.
- `in_janelamento_pcmSample`  in  DATA_W: signed sample from `out_overlap_pcmSample`.
- `in_janelamento_armazenarDados`  in  1: frame-start marker, qualified by valid.
- `in_janelamento_valid`  in  1: input sample present.
- `in_janelamento_ready`  out  1: input accepted when valid && ready.
- `out_janelamento_sample`  out  DATA_W: signed windowed sample.
- `out_janelamento_fimQuadro`  out  1: marks the last sample (index N-1) of a frame.
- `out_janelamento_erro`  out  1: sticky framing-error flag.
- `out_janelamento_valid`  out  1: output sample present.
- `out_janelamento_ready`  in  1: downstream accepts.

## Operation
- **Frame index.** `idx` runs 0..N-1 and advances on each accepted input. It wraps from N-1 to 0. The sample at N-1 carries fimQuadro=1.
- **Frame start marker.**
  - Marker with idx==0: normal start.
  - Marker with idx!=0: the sample is treated as idx 0 and the counter continues at 1. erro sets and stays set until reset. The truncated frame never gets a fimQuadro.
  - No marker at idx==0: the sample is accepted. Framing is counter-driven.
- **Coefficient.** c(n) = round(32768·(0.54 − 0.46·cos(2πn/(N−1)))). The ROM holds N/2 entries. Address = n < N/2 ? n : N−1−n.
- **Arithmetic.** p = signed(x)·signed({0,c}), width DATA_W+COEF_W+1. y = (p + 2^14) >>> 15 (round half up), truncated to DATA_W bits. c < 32768, so no saturation is needed.
- **Pipeline.**
  - Stage 1 registers the sample, the ROM output and the fimQuadro tag.
  - Stage 2 registers the product-rounded result.
  - Each stage has its own valid bit.
- **Flow control.** en = out_ready || !valid_s2. All stages advance only when en is high. in_ready = en.

## Timing
- **Latency.** A sample accepted at edge k appears with out_valid=1 after edge k+2 when there is no backpressure.
- **Throughput.** One sample per cycle.
- **Handshake.** Output data, fimQuadro and valid hold stable while valid && !ready. No sample is dropped or duplicated. Order is preserved.
- **in_ready** is combinational from out_ready. There is no combinational path from in_valid to out_valid.
- **Reset values** while reset=0:
  - out_valid=0, out_sample=0, fimQuadro=0, erro=0, in_ready=0.
  - idx=0; stage valids=0.
- **Reset mid-frame.** The in-flight samples are discarded. The next accepted sample is idx 0, whatever the marker.
- **Simultaneous events.** An input is accepted on the same edge as an output is consumed while the pipeline is full. An idx wrap and a marker can coincide; idx stays 0 and no error is raised.

## Structure
- `janelamento_pkg` holds:
  - DATA_W and COEF_W defaults, and the rounding constant (2^14).
  - `coef_t` (logic [COEF_W-1:0]).
  - A constant function `hamming_coef(n, N)` used for ROM elaboration.
- Sub-module `hamming_rom`: N/2 entries, synchronous read, address width $clog2(N/2). It is filled at elaboration from the package function and is read with the stage-1 enable.
- Top-level `janelamento` contains the counter, the error flag, the pipeline registers and the multiply.

## Test plan
- **Constant frame, N=256, out_ready=1.** Feed 256 samples of 16384, marker on the first. Expect:
  - out[0]=1311 (c=2621); out[127]=out[128]=16384 (c=32767); out[255]=1311.
  - fimQuadro only on out[255]; first out_valid 2 cycles after first accept.
- **Negative rounding.** Feed -16384 at idx 0. Expect out=-1310.
- **Backpressure.** Stream ramp 0..255; hold out_ready=0 for 10 cycles at sample 50. Expect:
  - in_ready=0 within the same cycle once both stages are full.
  - The output sequence is identical to the no-stall golden model with no gaps or duplicates.
- **Framing error.** Assert the marker at idx 100. Expect:
  - erro rises on that accept and stays high.
  - That sample uses c=2621.
  - fimQuadro is next seen 255 samples later; the frame cut at idx 100 is never tagged.
- **Reset mid-frame.** Assert reset at idx 60 with both stages valid. Expect all outputs at reset values. After release, a 256-sample frame produces a correct output with fimQuadro on its 256th sample.
- **Continuous throughput.** Feed 512 back-to-back samples with out_ready=1. Expect 512 outputs on consecutive cycles and fimQuadro on outputs 255 and 511.

Source files
------------

// File: rtl/janelamento_pkg.sv
// Shared types and constants for the Hamming-window stage.
// Coefficients are Q1.15 and built at elaboration time.
package janelamento_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int RND        = 1 << 14;

  localparam real PI = 3.141592653589793;

  typedef logic [COEF_W_DEF-1:0] coef_t;

  function automatic coef_t hamming_coef(
    input int n,
    input int len
  );
    real w;
    w = 0.54 - 0.46 * $cos(2.0 * PI * real'(n)
                           / real'(len - 1));
    w = 32768.0 * w;
    return coef_t'($rtoi(w + 0.5));
  endfunction

endpackage

// File: rtl/janelamento_rom.sv
// Half-frame Hamming coefficient ROM, synchronous read.
// The second half of the window is served by address mirroring.
module hamming_rom
  import janelamento_pkg::*;
#(
  parameter int N      = 256,
  parameter int COEF_W = COEF_W_DEF,
  parameter int AW     = $clog2(N / 2)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [AW-1:0]     addr_i,
  output logic [COEF_W-1:0] data_o
);

  logic [COEF_W-1:0] rom [N/2];
  logic [COEF_W-1:0] data_q;

  for (genvar g = 0; g < N / 2; g++) begin : g_rom
    assign rom[g] = COEF_W'(hamming_coef(g, N));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= rom[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/janelamento.sv
// Hamming-window stage: frame counter, sticky framing error and
// a two-stage stall-all pipeline (coef fetch, multiply-round).
module janelamento
  import janelamento_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int N      = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_janelamento_pcmSample,
  input  logic                     in_janelamento_armazenarDados,
  input  logic                     in_janelamento_valid,
  output logic                     in_janelamento_ready,
  output logic signed [DATA_W-1:0] out_janelamento_sample,
  output logic                     out_janelamento_fimQuadro,
  output logic                     out_janelamento_erro,
  output logic                     out_janelamento_valid,
  input  logic                     out_janelamento_ready
);

  localparam int IW = $clog2(N);
  localparam int AW = $clog2(N / 2);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam int SH = COEF_W - 1;

  logic en;
  logic acc;
  logic mk;

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic [IW-1:0] eidx;
  logic          erro_q;
  logic          erro_d;
  logic          fim;

  logic [AW-1:0]     rom_addr;
  logic [COEF_W-1:0] c1;

  logic                     v1_q;
  logic                     fim1_q;
  logic signed [DATA_W-1:0] x1_q;

  logic                     v2_q;
  logic                     fim2_q;
  logic signed [DATA_W-1:0] y2_q;
  logic signed [DATA_W-1:0] y2_d;
  logic signed [PW-1:0]     prod;

  assign en  = out_janelamento_ready || !v2_q;
  assign acc = in_janelamento_valid && in_janelamento_ready;
  assign mk  = in_janelamento_armazenarDados;

  assign in_janelamento_ready = en && reset;

  // A marker forces the sample to position 0 of a new frame.
  always_comb begin
    eidx   = mk ? '0 : idx_q;
    fim    = (eidx == IW'(N - 1));
    idx_d  = idx_q;
    erro_d = erro_q;
    if (acc) begin
      idx_d = fim ? '0 : eidx + 1'b1;
      if (mk && (idx_q != '0)) begin
        erro_d = 1'b1;
      end
    end
  end

  always_comb begin
    rom_addr = AW'(eidx);
    if (eidx >= IW'(N / 2)) begin
      rom_addr = AW'(IW'(N - 1) - eidx);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      erro_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      erro_q <= erro_d;
    end
  end

  hamming_rom #(
    .N      (N),
    .COEF_W (COEF_W),
    .AW     (AW)
  ) u_rom (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (en),
    .addr_i (rom_addr),
    .data_o (c1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      fim1_q <= 1'b0;
      x1_q   <= '0;
    end else if (en) begin
      v1_q   <= acc;
      fim1_q <= fim;
      x1_q   <= in_janelamento_pcmSample;
    end
  end

  // Coefficient is below 1.0 in Q1.15, so the result never overflows.
  assign prod = $signed(x1_q) * $signed({1'b0, c1});
  assign y2_d = DATA_W'((prod + PW'(RND)) >>> SH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_q   <= 1'b0;
      fim2_q <= 1'b0;
      y2_q   <= '0;
    end else if (en) begin
      v2_q   <= v1_q;
      fim2_q <= fim1_q && v1_q;
      y2_q   <= y2_d;
    end
  end

  assign out_janelamento_sample    = y2_q;
  assign out_janelamento_fimQuadro = fim2_q;
  assign out_janelamento_valid     = v2_q;
  assign out_janelamento_erro      = erro_q;

endmodule

// File: tb/tb_janelamento.sv
// Scoreboard bench for janelamento with an independent
// Hamming/rounding model and per-test boundary checks.
module tb_janelamento;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic signed [15:0] in_s;
  logic               in_mk;
  logic               in_v;
  logic               in_rdy;
  logic signed [15:0] o_s;
  logic               o_fim;
  logic               o_err;
  logic               o_v;
  logic               o_rdy;

  janelamento dut (
    .clk                           (clk),
    .reset                         (reset),
    .in_janelamento_pcmSample      (in_s),
    .in_janelamento_armazenarDados (in_mk),
    .in_janelamento_valid          (in_v),
    .in_janelamento_ready          (in_rdy),
    .out_janelamento_sample        (o_s),
    .out_janelamento_fimQuadro     (o_fim),
    .out_janelamento_erro          (o_err),
    .out_janelamento_valid         (o_v),
    .out_janelamento_ready         (o_rdy)
  );

  typedef struct {
    logic signed [15:0] y;
    bit                 fim;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   m_idx = 0;
  bit   m_err = 0;
  bit   chk_lat = 0;
  int   out_cnt = 0;
  int   first_out_cyc = 0;
  int   last_out_cyc = 0;
  int   fim_pos[$];
  logic signed [15:0] out_log [1024];

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int coef(input int n);
    real v;
    v = 0.54 - 0.46 * $cos(2.0 * 3.141592653589793
                           * real'(n) / 255.0);
    return int'($floor(32768.0 * v + 0.5));
  endfunction

  function automatic logic signed [15:0] wnd(
    input logic signed [15:0] x, input int c);
    longint p;
    p = longint'(x) * longint'(c);
    return 16'((p + 16384) >>> 15);
  endfunction

  task automatic model_push(input logic signed [15:0] x,
                            input bit mk);
    exp_t e;
    int   ei;
    ei = mk ? 0 : m_idx;
    if (mk && m_idx != 0) m_err = 1'b1;
    e.y   = wnd(x, coef(ei));
    e.fim = (ei == 255);
    e.cyc = cyc;
    sb.push_back(e);
    m_idx = (ei == 255) ? 0 : ei + 1;
  endtask

  task automatic step(input bit v,
                      input logic signed [15:0] x,
                      input bit mk, input bit ordy,
                      output bit acc);
    exp_t e;
    @(negedge clk);
    in_v  = v;
    in_s  = x;
    in_mk = mk;
    o_rdy = ordy;
    #1;
    chk("erro", o_err, m_err);
    if (o_v && !o_rdy && sb.size() != 0) begin
      chk("stall_sample", o_s, sb[0].y);
      chk("stall_fim", o_fim, sb[0].fim);
    end
    if (o_v && o_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sample", o_s, e.y);
        chk("fim", o_fim, e.fim);
        if (chk_lat) begin
          chk("latency", cyc - e.cyc, 2);
          chk_lat = 0;
        end
        if (out_cnt == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        if (out_cnt < 1024) out_log[out_cnt] = o_s;
        if (o_fim) fim_pos.push_back(out_cnt);
        out_cnt++;
      end
    end
    acc = v && in_rdy;
    if (acc) model_push(x, mk);
    cyc++;
  endtask

  task automatic send(input logic signed [15:0] x,
                      input bit mk);
    bit acc;
    int n;
    n = 0;
    acc = 0;
    while (!acc && n < 20) begin
      step(1'b1, x, mk, 1'b1, acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step(1'b0, 16'sd0, 1'b0, 1'b1, acc);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    step(1'b0, 16'sd0, 1'b0, 1'b1, acc);
  endtask

  task automatic clr_stats();
    out_cnt = 0;
    fim_pos.delete();
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    reset = 1'b0;
    in_v  = 1'b0;
    in_mk = 1'b0;
    o_rdy = 1'b1;
    #1;
    if (check) begin
      chk("rst_valid", o_v, 0);
      chk("rst_sample", o_s, 0);
      chk("rst_fim", o_fim, 0);
      chk("rst_erro", o_err, 0);
      chk("rst_in_ready", in_rdy, 0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    m_idx = 0;
    m_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin : main
    bit                 acc;
    logic signed [15:0] x;
    logic signed [15:0] x100;
    int                 i;
    int                 sc;
    int                 guard;
    int                 c0;

    reset = 1'b0;
    in_v  = 1'b0;
    in_s  = '0;
    in_mk = 1'b0;
    o_rdy = 1'b1;
    x100  = '0;

    // constant frame
    do_reset(1'b1);
    clr_stats();
    chk_lat = 1;
    for (int k = 0; k < 256; k++) send(16'sd16384, k == 0);
    drain();
    chk("t1_count", out_cnt, 256);
    chk("t1_out0", out_log[0], 1311);
    chk("t1_out127", out_log[127], 16384);
    chk("t1_out128", out_log[128], 16384);
    chk("t1_out255", out_log[255], 1311);
    chk("t1_nfim", fim_pos.size(), 1);
    if (fim_pos.size() > 0) chk("t1_fim_pos", fim_pos[0], 255);

    // negative rounding at idx 0
    clr_stats();
    send(-16'sd16384, 1'b1);
    drain();
    chk("t2_neg", out_log[0], -1310);

    // backpressure on a ramp
    do_reset(1'b0);
    clr_stats();
    i = 0;
    sc = 0;
    guard = 0;
    while (i < 256 && guard < 2000) begin
      bit ordy;
      ordy = !(i >= 50 && sc < 10);
      x = 16'(i * 128 - 16384);
      step(1'b1, x, i == 0, ordy, acc);
      if (!ordy) begin
        sc++;
        chk("t3_in_ready", in_rdy, 0);
      end
      if (acc) i++;
      guard++;
    end
    chk("t3_sent", i, 256);
    drain();
    chk("t3_count", out_cnt, 256);
    chk("t3_stall_cycles", sc, 10);

    // framing error at idx 100
    do_reset(1'b0);
    clr_stats();
    for (int k = 0; k < 400; k++) begin
      x = 16'($urandom_range(65535));
      if (k == 100) x100 = x;
      send(x, (k == 0) || (k == 100));
    end
    drain();
    chk("t4_erro", o_err, 1);
    chk("t4_nfim", fim_pos.size(), 1);
    if (fim_pos.size() > 0) chk("t4_fim_pos", fim_pos[0], 355);
    chk("t4_out100", out_log[100],
        16'((longint'(x100) * 2621 + 16384) >>> 15));

    // reset mid-frame
    do_reset(1'b0);
    clr_stats();
    for (int k = 0; k < 60; k++) begin
      send(16'($urandom_range(65535)), k == 0);
    end
    do_reset(1'b1);
    clr_stats();
    for (int k = 0; k < 256; k++) begin
      send(16'($urandom_range(65535)), 1'b0);
    end
    drain();
    chk("t5_count", out_cnt, 256);
    chk("t5_nfim", fim_pos.size(), 1);
    if (fim_pos.size() > 0) chk("t5_fim_pos", fim_pos[0], 255);

    // continuous throughput
    do_reset(1'b0);
    clr_stats();
    c0 = cyc;
    for (int k = 0; k < 512; k++) begin
      send(16'($urandom_range(65535)), k == 0);
    end
    chk("t6_in_cycles", cyc - c0, 512);
    drain();
    chk("t6_count", out_cnt, 512);
    chk("t6_span", last_out_cyc - first_out_cyc, 511);
    chk("t6_nfim", fim_pos.size(), 2);
    if (fim_pos.size() > 1) begin
      chk("t6_fim0", fim_pos[0], 255);
      chk("t6_fim1", fim_pos[1], 511);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
